// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and RAM fetch initiator presenting instructions over valid/ready
// Optional feature macro: FETCH_HALT_EN (stop fetching after an all-ones halt word is transferred).
module instr_fetch_unit #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] fetch_address,
  input  logic [DATA_W-1:0] fetch_out,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       fetch_count
`ifdef FETCH_HALT_EN
  ,
  output logic              halted
`endif
);

  localparam logic [2:0] LAT_CNT = 3'(RAM_LATENCY);

`ifdef FETCH_HALT_EN
  localparam logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}};
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALTED} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [15:0]         count_q, count_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                transfer;
  logic                redirect;
`ifdef FETCH_HALT_EN
  logic                halt_pend_q, halt_pend_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      cnt_q   <= '0;
`ifdef FETCH_HALT_EN
      halt_pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
`ifdef FETCH_HALT_EN
      halt_pend_q <= halt_pend_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
`ifdef FETCH_HALT_EN
    halt_pend_d = halt_pend_q;
`endif
    // instr_valid is only ever high in HOLD, so this is the handshake edge
    transfer = valid_q && instr_ready;
    redirect = branch_taken;

    case (state_q)
      S_REQ: begin
        state_d = S_WAIT;
        cnt_d   = 3'd1;
      end
      S_WAIT: begin
        if (cnt_q == LAT_CNT) begin
          instr_d = fetch_out;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
          addr_d  = pc_q + ADDR_W'(1);
          state_d = S_HOLD;
`ifdef FETCH_HALT_EN
          halt_pend_d = (fetch_out == HALT_WORD);
`endif
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_HOLD: begin
        if (transfer) begin
          valid_d = 1'b0;
          count_d = count_q + 16'd1;
          state_d = S_REQ;
`ifdef FETCH_HALT_EN
          // a transferred halt word parks the unit; a same-edge branch cannot revive it
          if (halt_pend_q) begin
            state_d  = S_HALTED;
            redirect = 1'b0;
          end
`endif
        end
      end
`ifdef FETCH_HALT_EN
      S_HALTED: begin
        redirect = 1'b0;
      end
`endif
      default: begin
        state_d = S_REQ;
      end
    endcase

    // Redirect discards any in-flight or held fetch, including a capture on this edge
    if (redirect) begin
      pc_d    = branch_target;
      addr_d  = branch_target;
      instr_d = instr_q;
      valid_d = 1'b0;
      state_d = S_REQ;
`ifdef FETCH_HALT_EN
      halt_pend_d = 1'b0;
`endif
    end
  end

  assign fetch_address = addr_q;
  assign instr         = instr_q;
  assign instr_valid   = valid_q;
  assign pc            = pc_q;
  assign fetch_count   = count_q;
`ifdef FETCH_HALT_EN
  assign halted        = (state_q == S_HALTED);
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-side initiator for the RAM fetch port: drives fetch_address, captures fetch_out, presents a 32-bit instruction to the decode/execute wiring over a valid/ready handshake.
- Owns the program counter (PC), sequential increment, and branch redirect.
- Sits between the Ram fetch port and the top-level system wiring's instr input.

Parameters:
- ADDR_W, 16, width of PC and fetch_address (word address).
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- RAM_LATENCY, 1, cycles from fetch_address presented to fetch_out valid (legal range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_address  output  ADDR_W  RAM fetch port address.
- fetch_out  input  DATA_W  RAM fetch port read data.
- instr  output  DATA_W  held instruction to decode.
- instr_valid  output  1  instr holds an unconsumed instruction.
- instr_ready  input  1  decode accepts instr this cycle.
- branch_taken  input  1  one-cycle redirect request.
- branch_target  input  ADDR_W  new PC when branch_taken.
- pc  output  ADDR_W  address of the next fetch.
- fetch_count  output  16  count of accepted instructions, wraps at 16'hFFFF to 0.

Behaviour:
- Clocking and reset:
  - Single clock domain; clk and rst are the only clock/reset.
  - Reset is synchronous and active-high, sampled on the rising edge of clk.
  - rst has priority over all other inputs.
- Reset values: state=REQ, pc=RESET_PC, fetch_address=RESET_PC, instr=0, instr_valid=0, fetch_count=0, latency counter=0.
- fetch_address is a registered copy of pc. It is stable throughout REQ and WAIT.
- States:
  - REQ: present pc. Next state is WAIT, with cnt=1.
  - WAIT: if cnt==RAM_LATENCY, set instr<=fetch_out, instr_valid<=1, pc<=pc+1, and go to HOLD. Otherwise cnt<=cnt+1.
  - HOLD: instr and instr_valid are held stable while instr_ready=0. A transfer occurs on an edge where instr_valid and instr_ready are both 1. On transfer: instr_valid<=0, fetch_count<=fetch_count+1, next state REQ.
- Latency and throughput:
  - First instr_valid is asserted RAM_LATENCY+1 cycles after the cycle rst is sampled low.
  - Maximum throughput is one instruction per RAM_LATENCY+2 cycles when instr_ready is held high.
- PC arithmetic: pc+1 is modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000 with no flag.
- Branch redirect, any state:
  - On branch_taken=1: pc<=branch_target, fetch_address<=branch_target, instr_valid<=0, next state REQ.
  - Any in-flight fetch is discarded; fetch_out is not captured that cycle.
- Branch in the same cycle as a transfer:
  - The transfer completes and fetch_count increments.
  - The redirect then applies as above.
- Branch during WAIT on the capture cycle: the redirect wins and the captured data is dropped.
- instr_ready while instr_valid=0 is ignored.
- Reset mid-operation (any state, including HOLD with instr_valid=1): all registers take their reset values on that edge; the pending instruction is lost.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - If the WAIT capture sees fetch_out==32'hFFFF_FFFF, the halt word is presented and handshaken normally.
  - After its transfer, the unit enters HALTED instead of REQ.
  - HALTED: no fetches, instr_valid=0, pc frozen. branch_taken is ignored.
  - Output halted=1 in HALTED, 0 otherwise; halted is cleared only by rst.
- Undefined:
  - 32'hFFFF_FFFF is treated as an ordinary instruction.
  - The halted port and the HALTED state do not exist.

Test Plan:
- Reset/first fetch: RESET_PC=0, RAM_LATENCY=1, RAM word0=32'h1234_5678, instr_ready=1 -> fetch_address=0 in cycle 0; instr_valid=1 with instr=32'h1234_5678 in cycle 2; pc=1; fetch_count=1 after transfer.
- Backpressure: instr_ready=0 for 5 cycles after instr_valid -> instr and pc stable and no new fetch_address change for all 5 cycles; transfer on the cycle ready rises; next fetch at address 1.
- Branch during WAIT: RAM_LATENCY=3, branch_taken=1 with target 16'h0040 in the second WAIT cycle -> old fetch dropped; fetch_address=16'h0040 next cycle; next instr is RAM[16'h0040].
- Wrap and branch+transfer collision:
  - Branch to 16'hFFFF and fetch twice -> addresses 16'hFFFF then 16'h0000.
  - Branch asserted on a transfer edge -> fetch_count increments and pc=target.
- Reset in HOLD: instr_valid=1, assert rst for one cycle -> next cycle instr_valid=0, pc=RESET_PC, fetch_count=0.
- FETCH_HALT_EN: RAM word2=32'hFFFF_FFFF -> three transfers, then halted=1, fetch_address frozen at 3, branch_taken ignored, rst clears halted.
